// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU with single-cycle logic/shift/add ops,
// a radix-2 Booth signed multiplier and a signed restoring divider, each
// iterating one bit per cycle. Results are registered and held until the
// next done pulse.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             IncPC,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] C_out_HI,
    output logic [WIDTH-1:0] C_out_LO
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Shift amounts are carried one bit wider than the field so WIDTH itself
    // is representable (needed for the complementary rotate shift).
    localparam logic [SHW:0]   WIDTH_S = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0] LAST    = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [4:0]         op_q, op_d;
    logic               inc_q, inc_d;
    // acc: Booth partial product (HI side) or divider partial remainder;
    // one extra bit so the Booth add/sub of the most-negative multiplicand
    // cannot overflow.
    logic [WIDTH:0]     acc_q, acc_d;
    // qr: Booth multiplier/low product, or divider dividend/quotient.
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic               qm1_q, qm1_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   alu_lo;
    logic [SHW:0]       sh_amt;
    logic [SHW:0]       rot_amt;

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   a_in_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Single-cycle datapath on the latched operands
    always_comb begin
        sh_amt  = {1'b0, b_q[SHW-1:0]};
        // Non-power-of-two widths can carry a field value >= WIDTH; fold it
        // back so rotates stay a true rotation.
        rot_amt = (sh_amt >= WIDTH_S) ? (sh_amt - WIDTH_S) : sh_amt;
        alu_lo  = '0;
        if (inc_q) begin
            alu_lo = a_q + WIDTH'(1);
        end else begin
            case (op_q)
                OP_ADD:  alu_lo = a_q + b_q;
                OP_SUB:  alu_lo = a_q + (~b_q) + WIDTH'(1);
                OP_SHR:  alu_lo = a_q >> sh_amt;
                OP_SHRA: alu_lo = WIDTH'($signed(a_q) >>> sh_amt);
                OP_SHL:  alu_lo = a_q << sh_amt;
                OP_ROR:  alu_lo = (a_q >> rot_amt) | (a_q << (WIDTH_S - rot_amt));
                OP_ROL:  alu_lo = (a_q << rot_amt) | (a_q >> (WIDTH_S - rot_amt));
                OP_AND:  alu_lo = a_q & b_q;
                OP_OR:   alu_lo = a_q | b_q;
                OP_NEG:  alu_lo = (~a_q) + WIDTH'(1);
                OP_NOT:  alu_lo = ~a_q;
                default: alu_lo = '0;
            endcase
        end
    end

    // Iteration datapath: one Booth step and one restoring-divide step
    always_comb begin
        m_ext = {a_q[WIDTH-1], a_q};
        case ({qr_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase

        a_in_mag  = A[WIDTH-1]   ? ((~A) + WIDTH'(1))   : A;
        b_mag     = b_q[WIDTH-1] ? ((~b_q) + WIDTH'(1)) : b_q;
        div_shift = {acc_q[WIDTH-1:0], qr_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag};

        // Magnitude results are converted back to signed form at FIN:
        // quotient negative when signs differ, remainder follows A.
        quo_s = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ((~qr_q) + WIDTH'(1)) : qr_q;
        rem_s = a_q[WIDTH-1] ? ((~acc_q[WIDTH-1:0]) + WIDTH'(1)) : acc_q[WIDTH-1:0];
    end

    // Next-state and register updates for the control FSM
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        inc_d   = inc_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = A;
                    b_d   = B;
                    op_d  = opcode;
                    inc_d = IncPC;
                    cnt_d = '0;
                    qm1_d = 1'b0;
                    acc_d = '0;
                    if (!IncPC && opcode == OP_MUL) begin
                        qr_d    = B;
                        state_d = MUL;
                    end else if (!IncPC && opcode == OP_DIV && B != '0) begin
                        qr_d    = a_in_mag;
                        state_d = DIV;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            MUL: begin
                busy_d = 1'b1;
                acc_d  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                qr_d   = {booth_sum[0], qr_q[WIDTH-1:1]};
                qm1_d  = qr_q[0];
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == LAST) state_d = FIN;
            end
            DIV: begin
                busy_d = 1'b1;
                if (div_diff[WIDTH+1]) begin
                    acc_d = div_shift;
                    qr_d  = {qr_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = div_diff[WIDTH:0];
                    qr_d  = {qr_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                dz_d    = 1'b0;
                state_d = IDLE;
                if (inc_q) begin
                    hi_d = '0;
                    lo_d = alu_lo;
                end else if (op_q == OP_MUL) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = qr_q;
                end else if (op_q == OP_DIV) begin
                    if (b_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                end else begin
                    hi_d = '0;
                    lo_d = alu_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            inc_q   <= 1'b0;
            acc_q   <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            inc_q   <= inc_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign C_out_HI = hi_q;
    assign C_out_LO = lo_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (WIDTH=32) with hand-computed
// expected values and immediate-assertion checks.
module tb_alu_multicycle;

    localparam int W = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    logic         clock;
    logic         clear_n;
    logic         start;
    logic         IncPC;
    logic [4:0]   opcode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] C_out_HI;
    logic [W-1:0] C_out_LO;

    int checks   = 0;
    int errors   = 0;
    int overlaps = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .start    (start),
        .IncPC    (IncPC),
        .opcode   (opcode),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .C_out_HI (C_out_HI),
        .C_out_LO (C_out_LO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request, let edge k sample it, then scramble the operands.
    task automatic run_op(input logic inc, input logic [4:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        IncPC  = inc;
        opcode = op;
        A      = a;
        B      = b;
        start  = 1'b1;
        step();
        start  = 1'b0;
        IncPC  = 1'b0;
        A      = $urandom;
        B      = $urandom;
        opcode = 5'($urandom);
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        do begin
            step();
            cyc++;
            if (busy) busy_cyc++;
            if (busy && done) overlaps++;
        end while (!done && cyc < max_cyc);
    endtask

    task automatic single(input string tag, input logic inc, input logic [4:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_lo);
        int cyc;
        int bc;
        run_op(inc, op, a, b);
        wait_done(4, cyc, bc);
        chk({tag, "_lat"}, 64'(cyc), 64'd1);
        chk({tag, "_lo"},  64'(C_out_LO), 64'(exp_lo));
        chk({tag, "_hi"},  64'(C_out_HI), 64'd0);
    endtask

    task automatic multi(input string tag, input logic [4:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cyc;
        int bc;
        run_op(1'b0, op, a, b);
        wait_done(40, cyc, bc);
        chk({tag, "_lat"},  64'(cyc), 64'd33);
        chk({tag, "_busy"}, 64'(bc), 64'd32);
        chk({tag, "_hi"},   64'(C_out_HI), 64'(exp_hi));
        chk({tag, "_lo"},   64'(C_out_LO), 64'(exp_lo));
        chk({tag, "_dz"},   64'(div_zero), 64'd0);
    endtask

    initial begin
        int cyc;
        int bc;
        int dcnt;

        clear_n = 1'b1;
        start   = 1'b0;
        IncPC   = 1'b0;
        opcode  = '0;
        A       = '0;
        B       = '0;
        #2 clear_n = 1'b0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz",   64'(div_zero), 64'd0);
        chk("rst_hi",   64'(C_out_HI), 64'd0);
        chk("rst_lo",   64'(C_out_LO), 64'd0);

        // First edge after release accepts the start
        clear_n = 1'b1;
        run_op(1'b0, OP_ADD, 32'd5, 32'd7);
        chk("add_k_done", 64'(done), 64'd0);
        step();
        chk("add_done", 64'(done), 64'd1);
        chk("add_busy", 64'(busy), 64'd0);
        chk("add_lo",   64'(C_out_LO), 64'h0000000C);
        chk("add_hi",   64'(C_out_HI), 64'd0);

        // Back-to-back: start presented while done is high
        run_op(1'b0, OP_SUB, 32'd3, 32'd5);
        chk("add_pulse_end", 64'(done), 64'd0);
        chk("add_held",      64'(C_out_LO), 64'h0000000C);
        step();
        chk("sub_done", 64'(done), 64'd1);
        chk("sub_lo",   64'(C_out_LO), 64'hFFFFFFFE);

        // Mul -3*7 with an ignored start at cycle 10
        run_op(1'b0, OP_MUL, 32'hFFFFFFFD, 32'd7);
        bc  = 0;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (busy) bc++;
            if (busy && done) overlaps++;
            if (i == 9) begin
                start  = 1'b1;
                opcode = OP_ADD;
                A      = 32'd1;
                B      = 32'd1;
            end
            if (i == 10) start = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
        end
        chk("mul_lat",  64'(cyc), 64'd33);
        chk("mul_busy", 64'(bc), 64'd32);
        chk("mul_hi",   64'(C_out_HI), 64'hFFFFFFFF);
        chk("mul_lo",   64'(C_out_LO), 64'hFFFFFFEB);
        step();
        chk("mul_pulse", 64'(done), 64'd0);
        chk("mul_noq",   64'(busy), 64'd0);
        step();
        chk("mul_noq2",  64'(done), 64'd0);
        chk("mul_held",  64'(C_out_LO), 64'hFFFFFFEB);

        multi("mul_nn",  OP_MUL, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006);
        multi("mul_min", OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        multi("div_neg", OP_DIV, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD);
        multi("div_pn",  OP_DIV, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        multi("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // Divide by zero
        run_op(1'b0, OP_DIV, 32'h12345678, 32'd0);
        wait_done(40, cyc, bc);
        chk("dz_lat", 64'(cyc), 64'd1);
        chk("dz_lo",  64'(C_out_LO), 64'hFFFFFFFF);
        chk("dz_hi",  64'(C_out_HI), 64'h12345678);
        chk("dz_flag", 64'(div_zero), 64'd1);

        // Undefined opcode clears results and div_zero
        single("undef", 1'b0, 5'b00000, 32'h1234, 32'd5, 32'd0);
        chk("undef_dz", 64'(div_zero), 64'd0);

        single("ror",  1'b0, OP_ROR,  32'h80000001, 32'hFFFFFFE1, 32'hC0000000);
        single("shra", 1'b0, OP_SHRA, 32'h80000000, 32'd4,        32'hF8000000);
        single("shr",  1'b0, OP_SHR,  32'h80000000, 32'h00000024, 32'h08000000);
        single("shl",  1'b0, OP_SHL,  32'h00000001, 32'd31,       32'h80000000);
        single("rol",  1'b0, OP_ROL,  32'h80000001, 32'd1,        32'h00000003);
        single("and",  1'b0, OP_AND,  32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F);
        single("or",   1'b0, OP_OR,   32'hF0F0FFFF, 32'h0FF0F00F, 32'hFFF0FFFF);
        single("not",  1'b0, OP_NOT,  32'h0F0F0F0F, 32'd0,        32'hF0F0F0F0);
        single("negm", 1'b0, OP_NEG,  32'h80000000, 32'd0,        32'h80000000);
        single("inc",  1'b1, OP_MUL,  32'hFFFFFFFF, 32'd9,        32'h00000000);
        single("neg1", 1'b0, OP_NEG,  32'h00000001, 32'd0,        32'hFFFFFFFF);

        // Reset in the middle of a Mul aborts it
        run_op(1'b0, OP_MUL, 32'd5, 32'd5);
        for (int i = 1; i <= 12; i++) step();
        chk("abort_busy_pre", 64'(busy), 64'd1);
        clear_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_lo",   64'(C_out_LO), 64'd0);
        chk("abort_hi",   64'(C_out_HI), 64'd0);
        step();
        clear_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dcnt++;
        end
        chk("abort_nodone", 64'(dcnt), 64'd0);
        single("add_post", 1'b0, OP_ADD, 32'd1, 32'd1, 32'd2);

        chk("busy_done_overlap", 64'(overlaps), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
